// File: rtl/sequence_serializer.sv
// sequence_serializer
// Parallel-to-serial bit source that feeds the sequence detector's data_in.
// Words arrive over a valid/ready handshake and leave MSB-first on serial_out,
// with each bit held for BIT_CYCLES clocks. A one-word holding buffer lets the
// producer queue the next word so consecutive words stream with no idle gap.

module sequence_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             bit_strobe,
  output logic             word_done,
  output logic             busy
);

  // Counter widths. Both counters keep at least one bit so that the
  // BIT_CYCLES == 1 case (cycle counter pinned at zero) stays well formed.
  localparam int unsigned BW = (WIDTH > 1)      ? $clog2(WIDTH)      : 1;
  localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] sh_q,        sh_d;
  logic [WIDTH-1:0] hold_q,      hold_d;
  logic             hold_full_q, hold_full_d;
  logic [BW-1:0]    bit_cnt_q,   bit_cnt_d;
  logic [CW-1:0]    cyc_cnt_q,   cyc_cnt_d;
  logic             word_done_q, word_done_d;

  logic accept;
  logic cyc_end;
  logic bit_end;

  // Handshake and end-of-period decodes shared by the next-state logic.
  // Ready is forced low while reset is asserted so nothing can be accepted
  // on the edge that releases it.
  always_comb begin
    load_ready = !hold_full_q && !reset;
    accept     = load_valid && load_ready;
    cyc_end    = (cyc_cnt_q == CYC_LAST);
    bit_end    = (bit_cnt_q == BIT_LAST);
  end

  // Next-state logic. In SHIFT every clock either advances the cycle counter
  // or closes a bit period; the last bit period of a word decides whether the
  // shifter reloads from hold, reloads straight from the input (bypass), or
  // drops back to IDLE. A word offered mid-word goes into hold; hold can only
  // be written while empty because ready is low whenever it is full.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    cyc_cnt_d   = cyc_cnt_q;
    word_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sh_d      = load_data;
          bit_cnt_d = '0;
          cyc_cnt_d = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (accept) begin
          hold_d      = load_data;
          hold_full_d = 1'b1;
        end

        if (!cyc_end) begin
          cyc_cnt_d = cyc_cnt_q + CW'(1);
        end else begin
          cyc_cnt_d = '0;
          if (!bit_end) begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            sh_d      = {sh_q[WIDTH-2:0], 1'b0};
          end else begin
            word_done_d = 1'b1;
            bit_cnt_d   = '0;
            if (hold_full_q) begin
              sh_d        = hold_q;
              hold_full_d = 1'b0;
            end else if (accept) begin
              sh_d        = load_data;
              hold_full_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. Reset is asynchronous so the serial line returns to the
  // idle level immediately, discarding both the shifting and the held word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      cyc_cnt_q   <= '0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      word_done_q <= word_done_d;
    end
  end

  // Output decode. The serial line shows the shifter MSB only while a word is
  // in progress; the strobe marks the first clock of every bit period.
  always_comb begin
    busy       = (state_q == SHIFT);
    serial_out = busy ? sh_q[WIDTH-1] : IDLE_LEVEL;
    bit_strobe = busy && (cyc_cnt_q == '0);
    word_done  = word_done_q;
  end

endmodule
